instr_reg_ctrl: RTL

Write/read sequencer for the 32-entry instruction register. Arbitrates two instruction producers onto the register's single write port with round-robin fairness, allocates write addresses as a circular queue, and drives `read_pointer` so a single consumer drains instructions in arrival order. It sits between the producers/consumer and `instr_register`, and it drives every control input of that block.

---
 rtl/instr_reg_ctrl_if.sv | 47 ++++
 rtl/instr_reg_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/instr_reg_ctrl_if.sv
// Producer, write-port, consumer and status signals of the instruction register sequencer.
interface instr_reg_ctrl_if #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
);
  logic                     req0_valid;
  logic                     req0_ready;
  logic [3:0]               req0_opcode;
  logic signed [31:0]       req0_operand_a;
  logic signed [31:0]       req0_operand_b;
  logic                     req1_valid;
  logic                     req1_ready;
  logic [3:0]               req1_opcode;
  logic signed [31:0]       req1_operand_a;
  logic signed [31:0]       req1_operand_b;
  logic                     load_en;
  logic [ADDR_W-1:0]        write_pointer;
  logic [3:0]               opcode;
  logic signed [31:0]       operand_a;
  logic signed [31:0]       operand_b;
  logic [ADDR_W-1:0]        read_pointer;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [ADDR_W:0]          count;
  logic                     full;
  logic                     empty;

  // Controller side.
  modport slave (
    input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
    input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
    input  rd_ready,
    output req0_ready, req1_ready,
    output load_en, write_pointer, opcode, operand_a, operand_b,
    output read_pointer, rd_valid, count, full, empty
  );

  // Producer/consumer environment side.
  modport master (
    output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
    output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
    output rd_ready,
    input  req0_ready, req1_ready,
    input  load_en, write_pointer, opcode, operand_a, operand_b,
    input  read_pointer, rd_valid, count, full, empty
  );
endinterface

// File: rtl/instr_reg_ctrl.sv
// Round-robin arbiter plus circular-queue pointer management for the instruction register.
module instr_reg_ctrl #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic               clk,
  input logic               reset_n,
  instr_reg_ctrl_if.slave   bus
);
  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH);

  logic                prio_q, prio_d;           // 0: requester 0 wins a tie
  logic [ADDR_W-1:0]   wr_tail_q, wr_tail_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;         // reserved entries
  logic [ADDR_W:0]     committed_q, committed_d; // entries already written
  logic                load_en_q, load_en_d;
  logic [3:0]          opcode_q, opcode_d;
  logic signed [31:0]  opa_q, opa_d;
  logic signed [31:0]  opb_q, opb_d;

  logic full, grant0, grant1, rdy0, rdy1, acc0, acc1, accept, pop;

  // Combinational grant, handshake and status decode.
  always_comb begin
    full   = (count_q == DepthCnt);
    grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
    grant1 = bus.req1_valid && (!bus.req0_valid || prio_q);
    // Gating with reset_n keeps producers stalled while reset is held.
    rdy0   = grant0 && !full && reset_n;
    rdy1   = grant1 && !full && reset_n;
    acc0   = bus.req0_valid && rdy0;
    acc1   = bus.req1_valid && rdy1;
    accept = acc0 || acc1;
    pop    = (committed_q != '0) && bus.rd_ready;

    bus.req0_ready    = rdy0;
    bus.req1_ready    = rdy1;
    bus.load_en       = load_en_q;
    bus.write_pointer = wr_ptr_q;
    bus.opcode        = opcode_q;
    bus.operand_a     = opa_q;
    bus.operand_b     = opb_q;
    bus.read_pointer  = rd_ptr_q;
    bus.rd_valid      = (committed_q != '0);
    bus.count         = count_q;
    bus.full          = full;
    bus.empty         = (count_q == '0);
  end

  // Next-state for pointers, occupancy counters, priority and write payload.
  always_comb begin
    prio_d      = prio_q;
    wr_tail_d   = wr_tail_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    committed_d = committed_q;
    load_en_d   = accept;
    opcode_d    = opcode_q;
    opa_d       = opa_q;
    opb_d       = opb_q;

    if (accept) begin
      prio_d    = acc0;
      wr_ptr_d  = wr_tail_q;
      wr_tail_d = ADDR_W'(wr_tail_q + 1'b1);
      if (acc0) begin
        opcode_d = bus.req0_opcode;
        opa_d    = bus.req0_operand_a;
        opb_d    = bus.req0_operand_b;
      end else begin
        opcode_d = bus.req1_opcode;
        opa_d    = bus.req1_operand_a;
        opb_d    = bus.req1_operand_b;
      end
    end

    if (pop) begin
      rd_ptr_d = ADDR_W'(rd_ptr_q + 1'b1);
    end

    unique case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // The entry in flight on load_en lands in the register at this edge.
    unique case ({load_en_q, pop})
      2'b10:   committed_d = committed_q + 1'b1;
      2'b01:   committed_d = committed_q - 1'b1;
      default: committed_d = committed_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio_q      <= 1'b0;
      wr_tail_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      committed_q <= '0;
      load_en_q   <= 1'b0;
      opcode_q    <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
    end else begin
      prio_q      <= prio_d;
      wr_tail_q   <= wr_tail_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      committed_q <= committed_d;
      load_en_q   <= load_en_d;
      opcode_q    <= opcode_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
    end
  end
endmodule
